// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with pause/resume, expiry level and pulse,
// and a low-time warning. Decrements once every TICK_CYCLES clocks while running.
module countdown_timer #(
  parameter int unsigned   TICK_CYCLES    = 100_000_000,
  parameter logic [15:0]   WARN_THRESHOLD = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [15:0] time_left,
  output logic        running,
  output logic        expired,
  output logic        expired_pulse,
  output logic        warn
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    time_left_q, time_left_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           running_q, running_d;
  logic           expired_q, expired_d;
  logic           expired_pulse_q, expired_pulse_d;
  logic           warn_q, warn_d;
  logic [15:0]    dec_s;

  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
    logic [3:0] r;
    if (d > lim) begin
      r = lim;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [15:0] sanitise(input logic [15:0] v);
    return {sat_digit(v[15:12], 4'd9), sat_digit(v[11:8], 4'd9),
            sat_digit(v[7:4], 4'd5),   sat_digit(v[3:0], 4'd9)};
  endfunction

  // Subtract one second; each digit only moves when every lower digit borrows.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (t == 16'h0000) begin
      // zero never wraps to 99:59
    end else if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  always_comb begin
    state_d         = state_q;
    time_left_d     = time_left_q;
    presc_d         = presc_q;
    expired_pulse_d = 1'b0;
    dec_s           = bcd_dec(time_left_q);

    if (load) begin
      time_left_d = sanitise(load_value);
      state_d     = IDLE;
      presc_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (time_left_q == 16'h0000) begin
              state_d         = DONE;
              expired_pulse_d = 1'b1;
            end else begin
              state_d = RUN;
              presc_d = '0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        // The resume edge out of PAUSED counts like any RUN edge.
        RUN, PAUSED: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (presc_q == TICK_LAST) begin
            presc_d     = '0;
            time_left_d = dec_s;
            if (dec_s == 16'h0000) begin
              state_d         = DONE;
              expired_pulse_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end else begin
            presc_d = presc_q + PW'(1);
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
    warn_d    = ((state_d == RUN) || (state_d == PAUSED)) && (time_left_d <= WARN_THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      time_left_q     <= 16'h0000;
      presc_q         <= '0;
      running_q       <= 1'b0;
      expired_q       <= 1'b0;
      expired_pulse_q <= 1'b0;
      warn_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      time_left_q     <= time_left_d;
      presc_q         <= presc_d;
      running_q       <= running_d;
      expired_q       <= expired_d;
      expired_pulse_q <= expired_pulse_d;
      warn_q          <= warn_d;
    end
  end

  assign time_left     = time_left_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign expired_pulse = expired_pulse_q;
  assign warn          = warn_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expectations are queued with each
// stimulus step and compared against the outputs just after the clock edge.
module tb_countdown_timer;

  localparam int unsigned TICK = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic [15:0] time_left;
  logic        running;
  logic        expired;
  logic        expired_pulse;
  logic        warn;

  // {time_left, running, expired, expired_pulse, warn}
  typedef logic [19:0] exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  countdown_timer #(
    .TICK_CYCLES    (TICK),
    .WARN_THRESHOLD (16'h0010)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .load_value    (load_value),
    .start         (start),
    .pause         (pause),
    .time_left     (time_left),
    .running       (running),
    .expired       (expired),
    .expired_pulse (expired_pulse),
    .warn          (warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] tl, input logic r, input logic e,
                              input logic p, input logic w);
    return {tl, r, e, p, w};
  endfunction

  function automatic logic [15:0] bcd(input int s);
    return 16'((((s / 60) / 10) << 12) | (((s / 60) % 10) << 8) |
               (((s % 60) / 10) << 4) | ((s % 60) % 10));
  endfunction

  task automatic step(input string tag, input logic r, input logic ld,
                      input logic [15:0] lv, input logic st, input logic ps,
                      input exp_t e);
    exp_t x;
    exp_t obs;
    rst = r; load = ld; load_value = lv; start = st; pause = ps;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs = {time_left, running, expired, expired_pulse, warn};
    x = sb.pop_front();
    checks++;
    assert (obs === x) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (tl,run,exp,pulse,warn)", tag, obs, x);
    end
  endtask

  task automatic nop(input string tag, input exp_t e);
    step(tag, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, e);
  endtask

  task automatic do_load(input string tag, input logic [15:0] v, input exp_t e);
    step(tag, 1'b0, 1'b1, v, 1'b0, 1'b0, e);
  endtask

  task automatic do_start(input string tag, input exp_t e);
    step(tag, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, e);
  endtask

  // Follows a running countdown of s0 seconds for n cycles after the start edge.
  task automatic countdown(input string tag, input int s0, input int n);
    int   s;
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      s = s0 - (k / int'(TICK));
      if (s > 0)
        e = mk(bcd(s), 1'b1, 1'b0, 1'b0, (s <= 10));
      else if (k == s0 * int'(TICK))
        e = mk(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
      else
        e = mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      nop(tag, e);
    end
  endtask

  // Load v, start, and check the single decrement to nxt on the fourth edge.
  task automatic one_tick(input string tag, input logic [15:0] v, input logic [15:0] nxt,
                          input logic w0, input logic w1);
    do_load(tag, v, mk(v, 1'b0, 1'b0, 1'b0, 1'b0));
    do_start(tag, mk(v, 1'b1, 1'b0, 1'b0, w0));
    for (int k = 1; k < int'(TICK); k++) nop(tag, mk(v, 1'b1, 1'b0, 1'b0, w0));
    nop(tag, mk(nxt, 1'b1, 1'b0, 1'b0, w1));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_value = 16'h0000; start = 1'b0; pause = 1'b0;

    step("reset0", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    step("reset1", 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));

    // Basic countdown from 3 seconds
    do_load("basic_load", 16'h0003, mk(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0));
    do_start("basic_start", mk(16'h0003, 1'b1, 1'b0, 1'b0, 1'b1));
    countdown("basic", 3, 14);

    // Borrow chains
    one_tick("borrow_1000", 16'h1000, 16'h0959, 1'b0, 1'b0);
    one_tick("borrow_0100", 16'h0100, 16'h0059, 1'b0, 1'b0);
    one_tick("borrow_0010", 16'h0010, 16'h0009, 1'b1, 1'b1);

    // Pause sampled on edges 2..11 after start; decrement lands on edge 14
    do_load("pause_load", 16'h0005, mk(16'h0005, 1'b0, 1'b0, 1'b0, 1'b0));
    do_start("pause_start", mk(16'h0005, 1'b1, 1'b0, 1'b0, 1'b1));
    nop("pause_e1", mk(16'h0005, 1'b1, 1'b0, 1'b0, 1'b1));
    for (int k = 2; k <= 11; k++)
      step("pause_hold", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mk(16'h0005, 1'b0, 1'b0, 1'b0, 1'b1));
    nop("pause_e12", mk(16'h0005, 1'b1, 1'b0, 1'b0, 1'b1));
    nop("pause_e13", mk(16'h0005, 1'b1, 1'b0, 1'b0, 1'b1));
    nop("pause_e14", mk(16'h0004, 1'b1, 1'b0, 1'b0, 1'b1));

    // Zero start, ignored inputs in DONE, sanitising
    do_load("zero_load", 16'h0000, mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    do_start("zero_start", mk(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0));
    nop("zero_after", mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    do_start("done_start", mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    step("done_pause", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mk(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0));
    do_load("sanitise", 16'hAB7F, mk(16'h9959, 1'b0, 1'b0, 1'b0, 1'b0));
    step("idle_pause", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, mk(16'h9959, 1'b0, 1'b0, 1'b0, 1'b0));

    // Load and reset mid-run
    do_load("mid_load3", 16'h0003, mk(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0));
    do_start("mid_start", mk(16'h0003, 1'b1, 1'b0, 1'b0, 1'b1));
    countdown("mid_run", 3, 4);
    do_load("mid_reload", 16'h0030, mk(16'h0030, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 6; k++) nop("mid_idle", mk(16'h0030, 1'b0, 1'b0, 1'b0, 1'b0));
    do_start("mid_restart", mk(16'h0030, 1'b1, 1'b0, 1'b0, 1'b0));
    nop("mid_r1", mk(16'h0030, 1'b1, 1'b0, 1'b0, 1'b0));
    nop("mid_r2", mk(16'h0030, 1'b1, 1'b0, 1'b0, 1'b0));
    step("mid_rst", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    nop("post_rst", mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    do_start("post_rst_start", mk(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0));

    // Warn boundary from 12 seconds down to expiry, then reload
    do_load("warn_load", 16'h0012, mk(16'h0012, 1'b0, 1'b0, 1'b0, 1'b0));
    do_start("warn_start", mk(16'h0012, 1'b1, 1'b0, 1'b0, 1'b0));
    countdown("warn", 12, 50);
    do_load("warn_reload", 16'h0012, mk(16'h0012, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
